serial_tx_arbiter: RTL

Round-robin arbiter that shares one `serial_register` transmit channel (the GBT slow-control bit) among several 32-bit word producers, such as page readback, diagnostics and motor status. It sits between the producers and the `data_ib32` side of the serial register. It latches a winning word, issues a single load strobe, and tracks the register's busy handshake until the word has left. It then signals completion back to the winner.

---
 rtl/serial_tx_arbiter_pkg.sv | 24 ++
 rtl/serial_tx_arbiter_rr_pick.sv | 40 ++++
 rtl/serial_tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// MCPkg: shared types and constants for the GBT serial TX arbiter.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package MCPkg;

  localparam int SERIAL_TX_ARB_MAX_REQ = 16;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } serial_tx_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin selector, first request at/above i_ptr.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int REQUESTERS = 4
) (
  input  logic [REQUESTERS-1:0]         i_req,
  input  logic [$clog2(REQUESTERS)-1:0] i_ptr,
  output logic [REQUESTERS-1:0]         o_onehot,
  output logic [$clog2(REQUESTERS)-1:0] o_idx,
  output logic                          o_valid
);

  localparam int IW = $clog2(REQUESTERS);

  always_comb begin : p_pick
    int   cand;
    logic found;
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = int'(i_ptr) + i;
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      if (!found && i_req[IW'(cand)]) begin
        found                = 1'b1;
        o_onehot[IW'(cand)]  = 1'b1;
        o_idx                = IW'(cand);
      end
    end
    o_valid = found;
  end

endmodule

`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
// ----------------------------------------------------------------------------
// serial_tx_arbiter: round-robin sharing of one serial_register TX channel.
// Option macro SERIAL_TX_ARB_TIMEOUT_EN adds a per-phase abort.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_tx_arbiter
  import MCPkg::*;
#(
  parameter int g_requesters = 4,
  parameter int g_timeout    = 4096
) (
  input  ckrs_t                           ClkRs_ix,
  input  logic [g_requesters-1:0]         Req_ib,
  input  logic [g_requesters-1:0][31:0]   Data_ib32,
  output logic [g_requesters-1:0]         Grant_ob,
  output logic [g_requesters-1:0]         Done_ob,
  output logic [$clog2(g_requesters)-1:0] Owner_ob,
  output logic [31:0]                     TxData_ob32,
  output logic                            TxLoad_o,
  input  logic                            TxBusy_i,
  input  logic                            ClearFlags_i,
  output logic                            Timeout_o
);

  localparam int OW = $clog2(g_requesters);

  if (g_requesters < 2 || g_requesters > SERIAL_TX_ARB_MAX_REQ || g_timeout < 1)
  begin : g_unsupported_params
  end

  logic w_clk;
  logic w_rst_n;
  assign w_clk   = ClkRs_ix.clk;
  assign w_rst_n = ClkRs_ix.reset;

  serial_tx_arb_state_t    r_state;
  logic [OW-1:0]           r_ptr;
  logic [OW-1:0]           r_owner;
  logic [g_requesters-1:0] r_win;
  logic [31:0]             r_data;
  logic [g_requesters-1:0] r_grant;
  logic [g_requesters-1:0] r_done;
  logic                    r_load;

  logic [g_requesters-1:0] w_pick_onehot;
  logic [OW-1:0]           w_pick_idx;
  logic                    w_pick_valid;
  logic [OW-1:0]           w_next_ptr;

  rr_pick #(
    .REQUESTERS (g_requesters)
  ) u_rr_pick (
    .i_req    (Req_ib),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_next_ptr = (r_owner == OW'(g_requesters - 1)) ? '0 : r_owner + 1'b1;

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(g_timeout + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_expired;
  // Abort on the edge where the phase counter would reach g_timeout.
  assign w_expired = (r_cnt == CW'(g_timeout - 1));
  assign Timeout_o = r_timeout;
`else
  logic w_unused_clear;
  assign w_unused_clear = ClearFlags_i;
  assign Timeout_o      = 1'b0;
`endif

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_win   <= '0;
      r_data  <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_load  <= 1'b0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_load  <= 1'b0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      // A same-cycle abort below overrides this clear.
      if (ClearFlags_i) r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_onehot;
            r_win   <= w_pick_onehot;
            r_owner <= w_pick_idx;
            r_data  <= Data_ib32[w_pick_idx];
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_load  <= 1'b1;
          r_state <= WAIT_BUSY;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (TxBusy_i) begin
            r_state <= WAIT_IDLE;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (w_expired) begin
            r_state   <= IDLE;
            r_ptr     <= w_next_ptr;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        WAIT_IDLE: begin
          if (!TxBusy_i) begin
            r_done  <= r_win;
            r_ptr   <= w_next_ptr;
            r_state <= IDLE;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (w_expired) begin
            r_state   <= IDLE;
            r_ptr     <= w_next_ptr;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Grant_ob    = r_grant;
  assign Done_ob     = r_done;
  assign Owner_ob    = r_owner;
  assign TxData_ob32 = r_data;
  assign TxLoad_o    = r_load;

endmodule

`default_nettype wire
